// File: rtl/iiitb_tlc_vsense_if.sv
// Bundle of the detector, light and request signals that pass between the
// farm-road vehicle sensor and the traffic light controller side.
interface iiitb_tlc_vsense_if;
   logic       loop_raw;
   logic       exit_raw;
   logic [2:0] light_farm;
   logic       sensor;
   logic [3:0] vehicle_count;
   logic       err;
   logic [1:0] state;

   modport master (
      output loop_raw,
      output exit_raw,
      output light_farm,
      input  sensor,
      input  vehicle_count,
      input  err,
      input  state
   );

   modport slave (
      input  loop_raw,
      input  exit_raw,
      input  light_farm,
      output sensor,
      output vehicle_count,
      output err,
      output state
   );
endinterface

// File: rtl/iiitb_tlc_vsense.sv
// Farm-road vehicle sensor: synchronises and debounces the arrival/exit
// detectors, keeps a saturating queue count and raises a registered request.
module iiitb_tlc_vsense #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLDOFF_CYCLES  = 8
) (
   input  logic                clk,
   input  logic                rst,
   iiitb_tlc_vsense_if.slave   vs
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_SERVING = 2'd2,
      ST_HOLDOFF = 2'd3
   } state_t;

   localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYCLES);

   // Channel 0 is the arrival loop, channel 1 the exit detector.
   logic [1:0] w_raw;
   logic [1:0] w_event;

   assign w_raw = {vs.exit_raw, vs.loop_raw};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         logic       r_s1;
         logic       r_s2;
         logic       r_filt;
         logic       r_filt_prev;
         logic [3:0] r_db_cnt;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_s1        <= 1'b0;
               r_s2        <= 1'b0;
               r_filt      <= 1'b0;
               r_filt_prev <= 1'b0;
               r_db_cnt    <= 4'd0;
            end else begin
               r_s1        <= w_raw[gi];
               r_s2        <= r_s1;
               r_filt_prev <= r_filt;
               if (r_s2 != r_filt) begin
                  if (r_db_cnt == DB_LAST) begin
                     r_filt   <= r_s2;
                     r_db_cnt <= 4'd0;
                  end else begin
                     r_db_cnt <= r_db_cnt + 4'd1;
                  end
               end else begin
                  r_db_cnt <= 4'd0;
               end
            end
         end

         // Only accepted rising levels count as a vehicle event.
         assign w_event[gi] = r_filt & ~r_filt_prev;
      end
   endgenerate

   logic [3:0] r_count;
   logic       r_err;
   logic [3:0] w_count_next;
   logic       w_err_next;

   always_comb begin
      w_count_next = r_count;
      w_err_next   = r_err;
      case (w_event)
         2'b01: begin
            if (r_count == 4'd15) w_err_next = 1'b1;
            else                  w_count_next = r_count + 4'd1;
         end
         2'b10: begin
            if (r_count == 4'd0) w_err_next = 1'b1;
            else                 w_count_next = r_count - 4'd1;
         end
         default: begin
            w_count_next = r_count;
            w_err_next   = r_err;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 4'd0;
         r_err   <= 1'b0;
      end else begin
         r_count <= w_count_next;
         r_err   <= w_err_next;
      end
   end

   logic   w_farm_green;
   logic   w_queued;
   state_t r_state;
   state_t w_state_next;
   logic [7:0] r_hold;
   logic [7:0] w_hold_next;

   assign w_farm_green = (vs.light_farm == 3'b001);
   assign w_queued     = (r_count != 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_hold  <= 8'd0;
      end else begin
         r_state <= w_state_next;
         r_hold  <= w_hold_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_hold_next  = r_hold;
      case (r_state)
         ST_IDLE: begin
            if (w_queued) w_state_next = ST_REQUEST;
         end
         ST_REQUEST: begin
            if (w_farm_green) w_state_next = ST_SERVING;
         end
         ST_SERVING: begin
            if (!w_farm_green) begin
               w_state_next = ST_HOLDOFF;
               w_hold_next  = HOLD_LOAD;
            end
         end
         ST_HOLDOFF: begin
            // The count seen here is the one registered at this edge.
            if (r_hold <= 8'd1) begin
               w_hold_next  = 8'd0;
               w_state_next = w_queued ? ST_REQUEST : ST_IDLE;
            end else begin
               w_hold_next = r_hold - 8'd1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_hold_next  = 8'd0;
         end
      endcase
   end

   assign vs.sensor        = (r_state == ST_REQUEST) ||
                             ((r_state == ST_SERVING) && w_queued);
   assign vs.vehicle_count = r_count;
   assign vs.err           = r_err;
   assign vs.state         = r_state;

endmodule

// File: tb/tb_iiitb_tlc_vsense.sv
// Directed bench for the farm-road vehicle sensor: debounce latency, glitch
// rejection, serving/holdoff sequencing, saturation and asynchronous reset.
module tb_iiitb_tlc_vsense;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   iiitb_tlc_vsense_if vs_if ();

   iiitb_tlc_vsense #(
      .DEBOUNCE_CYCLES(4),
      .HOLDOFF_CYCLES (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vs (vs_if)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      vs_if.loop_raw   = 1'b0;
      vs_if.exit_raw   = 1'b0;
      vs_if.light_farm = 3'b100;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // 8 cycles high then 8 low: the count moves on the 7th edge of the high phase.
   task automatic pulse(input logic arr, input logic ext);
      vs_if.loop_raw = arr;
      vs_if.exit_raw = ext;
      repeat (8) tick();
      vs_if.loop_raw = 1'b0;
      vs_if.exit_raw = 1'b0;
      repeat (8) tick();
      $display("pulse arr=%0b ext=%0b -> count=%0d err=%0b state=%0d sensor=%0b",
               arr, ext, vs_if.vehicle_count, vs_if.err, vs_if.state, vs_if.sensor);
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (vs_if.sensor !== 1'b0) begin errors++; $display("FAIL reset_sensor: got %0b expected 0", vs_if.sensor); end
      checks++; if (vs_if.vehicle_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", vs_if.vehicle_count); end
      checks++; if (vs_if.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", vs_if.err); end
      checks++; if (vs_if.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", vs_if.state); end
      $display("test_reset done");
   endtask

   task automatic test_arrival_latency();
      logic [3:0] exp_cnt;
      logic [1:0] exp_st;
      logic       exp_sen;
      apply_reset();
      vs_if.loop_raw = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         exp_cnt = (k >= 7) ? 4'd1 : 4'd0;
         exp_st  = (k >= 8) ? 2'd1 : 2'd0;
         exp_sen = (k >= 8);
         checks++; if (vs_if.vehicle_count !== exp_cnt) begin errors++; $display("FAIL arrival_count edge %0d: got %0d expected %0d", k, vs_if.vehicle_count, exp_cnt); end
         checks++; if (vs_if.state !== exp_st) begin errors++; $display("FAIL arrival_state edge %0d: got %0d expected %0d", k, vs_if.state, exp_st); end
         checks++; if (vs_if.sensor !== exp_sen) begin errors++; $display("FAIL arrival_sensor edge %0d: got %0b expected %0b", k, vs_if.sensor, exp_sen); end
      end
      vs_if.loop_raw = 1'b0;
      repeat (10) tick();
      checks++; if (vs_if.vehicle_count !== 4'd1) begin errors++; $display("FAIL falling_no_event: got %0d expected 1", vs_if.vehicle_count); end
      $display("test_arrival_latency done: count=%0d state=%0d", vs_if.vehicle_count, vs_if.state);
   endtask

   task automatic test_glitch();
      apply_reset();
      vs_if.loop_raw = 1'b1;
      repeat (3) tick();
      vs_if.loop_raw = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         checks++; if (vs_if.vehicle_count !== 4'd0) begin errors++; $display("FAIL glitch_count cycle %0d: got %0d expected 0", k, vs_if.vehicle_count); end
         checks++; if (vs_if.sensor !== 1'b0) begin errors++; $display("FAIL glitch_sensor cycle %0d: got %0b expected 0", k, vs_if.sensor); end
      end
      $display("test_glitch done: count=%0d", vs_if.vehicle_count);
   endtask

   task automatic test_serving_holdoff();
      apply_reset();
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      checks++; if (vs_if.vehicle_count !== 4'd2) begin errors++; $display("FAIL serve_count2: got %0d expected 2", vs_if.vehicle_count); end
      checks++; if (vs_if.state !== 2'd1) begin errors++; $display("FAIL serve_request: got %0d expected 1", vs_if.state); end
      vs_if.light_farm = 3'b001;
      tick();
      checks++; if (vs_if.state !== 2'd2) begin errors++; $display("FAIL serve_enter: got %0d expected 2", vs_if.state); end
      checks++; if (vs_if.sensor !== 1'b1) begin errors++; $display("FAIL serve_sensor_busy: got %0b expected 1", vs_if.sensor); end
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      checks++; if (vs_if.vehicle_count !== 4'd0) begin errors++; $display("FAIL serve_count0: got %0d expected 0", vs_if.vehicle_count); end
      checks++; if (vs_if.state !== 2'd2) begin errors++; $display("FAIL serve_persist: got %0d expected 2", vs_if.state); end
      checks++; if (vs_if.sensor !== 1'b0) begin errors++; $display("FAIL serve_sensor_empty: got %0b expected 0", vs_if.sensor); end
      vs_if.light_farm = 3'b010;
      tick();
      checks++; if (vs_if.state !== 2'd3) begin errors++; $display("FAIL holdoff_enter: got %0d expected 3", vs_if.state); end
      vs_if.light_farm = 3'b001;
      for (int k = 2; k <= 8; k++) begin
         tick();
         if (k == 4) vs_if.light_farm = 3'b100;
         checks++; if (vs_if.state !== 2'd3) begin errors++; $display("FAIL holdoff_stay cycle %0d: got %0d expected 3", k, vs_if.state); end
      end
      tick();
      checks++; if (vs_if.state !== 2'd0) begin errors++; $display("FAIL holdoff_to_idle: got %0d expected 0", vs_if.state); end
      vs_if.light_farm = 3'b001;
      repeat (3) tick();
      checks++; if (vs_if.state !== 2'd0) begin errors++; $display("FAIL idle_ignores_green: got %0d expected 0", vs_if.state); end
      vs_if.light_farm = 3'b100;
      $display("test_serving_holdoff done: state=%0d", vs_if.state);
   endtask

   task automatic test_holdoff_arrival();
      logic [3:0] exp_cnt;
      logic [1:0] exp_st;
      logic       exp_sen;
      apply_reset();
      pulse(1'b1, 1'b0);
      vs_if.light_farm = 3'b001;
      tick();
      pulse(1'b0, 1'b1);
      checks++; if (vs_if.state !== 2'd2) begin errors++; $display("FAIL ho_serving: got %0d expected 2", vs_if.state); end
      vs_if.light_farm = 3'b010;
      vs_if.loop_raw   = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp_cnt = (k >= 7) ? 4'd1 : 4'd0;
         exp_st  = (k >= 9) ? 2'd1 : 2'd3;
         exp_sen = (k >= 9);
         checks++; if (vs_if.vehicle_count !== exp_cnt) begin errors++; $display("FAIL ho_count edge %0d: got %0d expected %0d", k, vs_if.vehicle_count, exp_cnt); end
         checks++; if (vs_if.state !== exp_st) begin errors++; $display("FAIL ho_state edge %0d: got %0d expected %0d", k, vs_if.state, exp_st); end
         checks++; if (vs_if.sensor !== exp_sen) begin errors++; $display("FAIL ho_sensor edge %0d: got %0b expected %0b", k, vs_if.sensor, exp_sen); end
      end
      vs_if.loop_raw   = 1'b0;
      vs_if.light_farm = 3'b100;
      repeat (8) tick();
      $display("test_holdoff_arrival done: state=%0d sensor=%0b", vs_if.state, vs_if.sensor);
   endtask

   task automatic test_count_limits();
      logic [3:0] exp_cnt;
      apply_reset();
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b1);
      checks++; if (vs_if.vehicle_count !== 4'd1) begin errors++; $display("FAIL simul_count: got %0d expected 1", vs_if.vehicle_count); end
      checks++; if (vs_if.err !== 1'b0) begin errors++; $display("FAIL simul_err: got %0b expected 0", vs_if.err); end
      pulse(1'b0, 1'b1);
      checks++; if ((vs_if.vehicle_count !== 4'd0) || (vs_if.err !== 1'b0)) begin errors++; $display("FAIL exit_to_zero: got count=%0d err=%0b expected 0/0", vs_if.vehicle_count, vs_if.err); end
      pulse(1'b0, 1'b1);
      checks++; if (vs_if.vehicle_count !== 4'd0) begin errors++; $display("FAIL underflow_count: got %0d expected 0", vs_if.vehicle_count); end
      checks++; if (vs_if.err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %0b expected 1", vs_if.err); end
      pulse(1'b1, 1'b0);
      checks++; if ((vs_if.vehicle_count !== 4'd1) || (vs_if.err !== 1'b1)) begin errors++; $display("FAIL err_sticky: got count=%0d err=%0b expected 1/1", vs_if.vehicle_count, vs_if.err); end
      apply_reset();
      for (int i = 1; i <= 16; i++) begin
         pulse(1'b1, 1'b0);
         exp_cnt = (i > 15) ? 4'd15 : 4'(i);
         checks++; if (vs_if.vehicle_count !== exp_cnt) begin errors++; $display("FAIL overflow_count arrival %0d: got %0d expected %0d", i, vs_if.vehicle_count, exp_cnt); end
         checks++; if (vs_if.err !== (i > 15)) begin errors++; $display("FAIL overflow_err arrival %0d: got %0b expected %0b", i, vs_if.err, (i > 15)); end
      end
      $display("test_count_limits done: count=%0d err=%0b", vs_if.vehicle_count, vs_if.err);
   endtask

   task automatic test_async_reset();
      apply_reset();
      repeat (5) pulse(1'b1, 1'b0);
      vs_if.light_farm = 3'b001;
      tick();
      tick();
      checks++; if ((vs_if.state !== 2'd2) || (vs_if.vehicle_count !== 4'd5) || (vs_if.sensor !== 1'b1)) begin errors++; $display("FAIL pre_reset: got state=%0d count=%0d sensor=%0b expected 2/5/1", vs_if.state, vs_if.vehicle_count, vs_if.sensor); end
      #3;
      rst = 1'b1;
      #1;
      checks++; if (vs_if.sensor !== 1'b0) begin errors++; $display("FAIL async_sensor: got %0b expected 0", vs_if.sensor); end
      checks++; if (vs_if.vehicle_count !== 4'd0) begin errors++; $display("FAIL async_count: got %0d expected 0", vs_if.vehicle_count); end
      checks++; if (vs_if.err !== 1'b0) begin errors++; $display("FAIL async_err: got %0b expected 0", vs_if.err); end
      checks++; if (vs_if.state !== 2'd0) begin errors++; $display("FAIL async_state: got %0d expected 0", vs_if.state); end
      #2;
      rst = 1'b0;
      vs_if.light_farm = 3'b100;
      tick();
      checks++; if ((vs_if.state !== 2'd0) || (vs_if.vehicle_count !== 4'd0)) begin errors++; $display("FAIL post_reset: got state=%0d count=%0d expected 0/0", vs_if.state, vs_if.vehicle_count); end
      $display("test_async_reset done: state=%0d count=%0d", vs_if.state, vs_if.vehicle_count);
   endtask

   initial begin
      test_reset();
      test_arrival_latency();
      test_glitch();
      test_serving_holdoff();
      test_holdoff_arrival();
      test_count_limits();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
